// File: rtl/opc5ls_timer_irq.sv
// opc5ls_timer_irq: bus-responder interval timer for the OPC5LS CPU.
// Four word registers (CTRL, RELOAD, COUNT, STATUS) sit in a window at BASE.
// Each access is stretched by WAIT_STATES stall cycles through clken.
// Counter expiry raises the sticky EXP flag, which drives the active-low int_b.
module opc5ls_timer_irq #(
  parameter logic [15:0] BASE        = 16'hFE00,
  parameter int          WAIT_STATES = 1,
  parameter int          PRESCALE    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        rnw,
  input  logic        mreq_b,
  output logic [15:0] rdata,
  output logic        sel,
  output logic        clken,
  output logic        int_b
);

  localparam logic [2:0]  WS      = 3'(WAIT_STATES);
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [2:0]  wcnt_q, wcnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        auto_q, auto_d;
  logic        exp_q, exp_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;

  logic commit;
  logic wr;
  logic tick;
  logic expire;

  assign sel    = !mreq_b && (address[15:2] == BASE[15:2]);
  assign clken  = !sel || (wcnt_q == WS);
  assign commit = sel && clken;
  assign wr     = commit && !rnw;
  assign tick   = en_q && (presc_q == PS_LAST);
  assign expire = tick && (count_q == 16'd0);
  // int_b depends only on flops, so no bus signal can glitch the interrupt
  assign int_b  = !(exp_q && ie_q);

  // Wait-state counter: advance while stalling, clear on completion or deselect
  always_comb begin
    wcnt_d = 3'd0;
    if (sel && (wcnt_q != WS)) begin
      wcnt_d = wcnt_q + 3'd1;
    end
  end

  // Read mux: driven only for a selected read so it can be OR-ed onto din
  always_comb begin
    rdata = 16'd0;
    if (sel && rnw) begin
      case (address[1:0])
        2'd0:    rdata = {13'd0, auto_q, ie_q, en_q};
        2'd1:    rdata = reload_q;
        2'd2:    rdata = count_q;
        default: rdata = {15'd0, exp_q};
      endcase
    end
  end

  // Prescaler and timer next-state; bus writes are applied after the tick so they win
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    auto_d   = auto_q;
    exp_d    = exp_q;
    reload_d = reload_q;
    count_d  = count_q;

    // Held at 0 while disabled, so enabling always starts a full tick period
    if (!en_q || (presc_q == PS_LAST)) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    if (tick) begin
      if (count_q == 16'd0) begin
        exp_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    if (wr) begin
      case (address[1:0])
        2'd0: begin
          en_d   = wdata[0];
          ie_d   = wdata[1];
          auto_d = wdata[2];
        end
        2'd1:    reload_d = wdata;
        2'd2:    count_d  = wdata;
        default: begin
          // A clear coinciding with expiry loses: the new event must not be dropped
          if (wdata[0] && !expire) begin
            exp_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q   <= 3'd0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      auto_q   <= 1'b0;
      exp_q    <= 1'b0;
      reload_q <= 16'd0;
      count_q  <= 16'd0;
      presc_q  <= 16'd0;
    end else begin
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      auto_q   <= auto_d;
      exp_q    <= exp_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
    end
  end

endmodule
